// File: rtl/bcd_subtractor_seq.sv
// Digit-serial packed-BCD subtractor (A - B), LSD first, sign + magnitude.
// Define BCD_SUB_MAGNITUDE_EN to convert negative results to magnitude.
module bcd_subtractor_seq #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] diff,
  output logic                neg,
  output logic                invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

`ifdef BCD_SUB_MAGNITUDE_EN
  typedef enum logic [1:0] {IDLE, SUB, COMP, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;
`endif

  state_t         state, nxt;
  logic [W-1:0]   ra, rb;
  logic [CW-1:0]  idx;
  logic           borrow;
  logic           last;
  logic           bad;
  logic [3:0]     dx, dy, dd;
  logic [4:0]     t;
  logic           bout;
  logic [W-1:0]   shifted;

  assign last = (idx == CW'(DIGITS - 1));

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1'b1;
    end
  end

  // Shared digit unit; COMP reuses it as 0 - diff digit
  always_comb begin
    dx = ra[3:0];
    dy = rb[3:0];
`ifdef BCD_SUB_MAGNITUDE_EN
    if (state == COMP) begin
      dx = 4'd0;
      dy = diff[3:0];
    end
`endif
    t    = {1'b0, dx} - {1'b0, dy} - {4'd0, borrow};
    bout = t[4];
    dd   = bout ? t[3:0] + 4'd10 : t[3:0];
  end

  assign shifted = (diff >> 4) | (W'(dd) << (W - 4));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (start) nxt = bad ? DONE : SUB;
      SUB: begin
        if (last) begin
`ifdef BCD_SUB_MAGNITUDE_EN
          nxt = bout ? COMP : DONE;
`else
          nxt = DONE;
`endif
        end
      end
`ifdef BCD_SUB_MAGNITUDE_EN
      COMP: if (last) nxt = DONE;
`endif
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SUB:  busy = 1'b1;
`ifdef BCD_SUB_MAGNITUDE_EN
      COMP: busy = 1'b1;
`endif
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra      <= '0;
      rb      <= '0;
      diff    <= '0;
      neg     <= 1'b0;
      invalid <= 1'b0;
      idx     <= '0;
      borrow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ra      <= a;
            rb      <= b;
            diff    <= '0;
            neg     <= 1'b0;
            invalid <= bad;
            idx     <= '0;
            borrow  <= 1'b0;
          end
        end
        SUB: begin
          ra     <= ra >> 4;
          rb     <= rb >> 4;
          diff   <= shifted;
          borrow <= last ? 1'b0 : bout;
          idx    <= last ? '0 : idx + 1'b1;
          if (last) neg <= bout;
        end
`ifdef BCD_SUB_MAGNITUDE_EN
        COMP: begin
          diff   <= shifted;
          borrow <= last ? 1'b0 : bout;
          idx    <= last ? '0 : idx + 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_subtractor_seq.sv
// Randomized self-checking bench for bcd_subtractor_seq against
// an integer-arithmetic decimal model.
module tb_bcd_subtractor_seq;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, neg, invalid;
  logic [W-1:0] diff;

  int tests = 0;
  int fails = 0;

  bcd_subtractor_seq #(.DIGITS(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .busy(busy), .done(done),
    .diff(diff), .neg(neg), .invalid(invalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [W-1:0] v);
    for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] ed, output bit en,
                       output bit ei, output int lat);
    int r;
    if (has_bad(x) || has_bad(y)) begin
      ed = '0; en = 1'b0; ei = 1'b1; lat = 1;
      return;
    end
    ei = 1'b0;
    r  = bcd2int(x) - bcd2int(y);
    if (r >= 0) begin
      ed = int2bcd(r); en = 1'b0; lat = D + 1;
    end else begin
      en = 1'b1;
`ifdef BCD_SUB_MAGNITUDE_EN
      ed = int2bcd(-r); lat = 2 * D + 1;
`else
      ed = int2bcd(10 ** D + r); lat = D + 1;
`endif
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) chk("busy_done_excl", longint'(busy & done), 0);
  end

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit repulse, input string nm);
    logic [W-1:0] ed;
    bit en, ei;
    int lat;
    int edges;
    bit tmo;
    model(x, y, ed, en, ei, lat);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(posedge clk);
    edges = 1;
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    tmo = 1'b0;
    while (1) begin
      @(negedge clk);
      if (done) break;
      chk({nm, " busy"}, longint'(busy), 1);
      if (repulse && edges == 2) begin
        start = 1'b1; a = 16'h0001; b = 16'h0000;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      edges++;
      if (edges > 3 * D + 4) begin
        tmo = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (tmo) begin
      chk({nm, " timeout"}, 1, 0);
      return;
    end
    chk({nm, " latency"}, edges, lat);
    chk({nm, " diff"}, longint'(diff), longint'(ed));
    chk({nm, " neg"}, longint'(neg), longint'(en));
    chk({nm, " invalid"}, longint'(invalid), longint'(ei));
    chk({nm, " busy_at_done"}, longint'(busy), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk({nm, " done_pulse"}, longint'(done), 0);
      chk({nm, " diff_hold"}, longint'(diff), longint'(ed));
    end
  endtask

  initial begin
    logic [W-1:0] ed;
    bit en, ei;
    int lat;
    logic [W-1:0] x, y;

    // Pin the model with hand-computed values
    model(16'h1234, 16'h0234, ed, en, ei, lat);
    chk("model 1234-0234", longint'(ed), 16'h1000);
    chk("model 1234 lat", lat, 5);
    model(16'h0100, 16'h0001, ed, en, ei, lat);
    chk("model 0100-0001", longint'(ed), 16'h0099);
    model(16'h0005, 16'h0012, ed, en, ei, lat);
    chk("model 0005-0012 neg", longint'(en), 1);
`ifdef BCD_SUB_MAGNITUDE_EN
    chk("model 0005-0012", longint'(ed), 16'h0007);
    chk("model 0005 lat", lat, 9);
`else
    chk("model 0005-0012", longint'(ed), 16'h9993);
    chk("model 0005 lat", lat, 5);
`endif
    model(16'h00A3, 16'h0001, ed, en, ei, lat);
    chk("model 00A3 inv", longint'(ei), 1);

    #1;
    chk("reset busy", longint'(busy), 0);
    chk("reset done", longint'(done), 0);
    chk("reset diff", longint'(diff), 0);
    chk("reset neg", longint'(neg), 0);
    chk("reset invalid", longint'(invalid), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h0234, 1'b0, "tp1");
    chk("tp1 lit", longint'(diff), 16'h1000);
    run_op(16'h0100, 16'h0001, 1'b0, "tp2");
    chk("tp2 lit", longint'(diff), 16'h0099);
    run_op(16'h0005, 16'h0012, 1'b0, "tp3");
`ifdef BCD_SUB_MAGNITUDE_EN
    chk("tp3 lit", longint'(diff), 16'h0007);
`else
    chk("tp3 lit", longint'(diff), 16'h9993);
`endif
    run_op(16'h00A3, 16'h0001, 1'b0, "tp4");
    chk("tp4 lit", longint'(invalid), 1);
    run_op(16'h9999, 16'h9999, 1'b1, "tp5");
    chk("tp5 lit", longint'(diff), 0);
    run_op(16'h0000, 16'h9999, 1'b0, "maxneg");
    run_op(16'h9999, 16'h0000, 1'b0, "maxpos");

    // Asynchronous reset in the middle of SUB
    @(negedge clk);
    a = 16'h9999; b = 16'h0001; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst busy", longint'(busy), 0);
    chk("arst done", longint'(done), 0);
    chk("arst diff", longint'(diff), 0);
    chk("arst neg", longint'(neg), 0);
    chk("arst invalid", longint'(invalid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h0042, 16'h0017, 1'b0, "tp6");
    chk("tp6 lit", longint'(diff), 16'h0025);

    for (int n = 0; n < 40; n++) begin
      x = ($urandom_range(0, 7) == 0) ? W'($urandom)
                                      : int2bcd($urandom_range(0, 9999));
      y = ($urandom_range(0, 7) == 0) ? W'($urandom)
                                      : int2bcd($urandom_range(0, 9999));
      run_op(x, y, n[0], "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
